// File: rtl/abs_bitserial_ctrl.sv
// Bit-serial two's-complement absolute value: one invert/increment slice reused over WIDTH cycles.
// Optional ABS_BITSERIAL_SAT_EN saturates the most-negative input to max positive.
module abs_bitserial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             slice_b, slice_sum;
`ifdef ABS_BITSERIAL_SAT_EN
  logic             low_zero_q, low_zero_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    sh_d      = sh_q;
    y_d       = y_q;
    sign_d    = sign_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
`ifdef ABS_BITSERIAL_SAT_EN
    low_zero_d = low_zero_q;
`endif
    // The operand is shifted right each step, so the current bit is always a_q[0].
    slice_b   = a_q[0] ^ sign_q;
    slice_sum = slice_b ^ carry_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = A;
          sign_d  = A[WIDTH-1];
          carry_d = A[WIDTH-1];
          cnt_d   = '0;
`ifdef ABS_BITSERIAL_SAT_EN
          low_zero_d = 1'b1;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        carry_d = slice_b & carry_q;
        sh_d    = {slice_sum, sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
`ifdef ABS_BITSERIAL_SAT_EN
        if (cnt_q != LastBit) begin
          low_zero_d = low_zero_q & ~a_q[0];
        end
`endif
        if (cnt_q == LastBit) begin
          state_d = StDone;
          y_d     = sh_d;
`ifdef ABS_BITSERIAL_SAT_EN
          // Sign set with all lower bits clear is the one input whose magnitude overflows.
          if (sign_q && low_zero_q) begin
            y_d = {1'b0, {(WIDTH - 1){1'b1}}};
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      sh_q    <= '0;
      y_q     <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef ABS_BITSERIAL_SAT_EN
      low_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sh_q    <= sh_d;
      y_q     <= y_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef ABS_BITSERIAL_SAT_EN
      low_zero_q <= low_zero_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign Y    = y_q;

endmodule

// File: tb/tb_abs_bitserial_ctrl.sv
// Self-checking bench for abs_bitserial_ctrl at WIDTH=8; honours ABS_BITSERIAL_SAT_EN.
module tb_abs_bitserial_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic         busy;
  logic         done;
  logic [W-1:0] Y;

  int vecs = 0;
  int errs = 0;

  abs_bitserial_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .busy (busy),
    .done (done),
    .Y    (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: |A| modulo 2^W, with optional saturation of the most-negative value.
  function automatic logic [W-1:0] ref_abs(input logic [W-1:0] a);
    int v;
    v = int'($signed(a));
    if (v < 0) v = -v;
`ifdef ABS_BITSERIAL_SAT_EN
    if (v >= (1 << (W - 1))) v = (1 << (W - 1)) - 1;
`endif
    return W'(v);
  endfunction

  // Called at a negedge with DUT in IDLE or DONE; returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] a, output int lat, output int nbusy);
    start = 1'b1;
    A     = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = W'($urandom);
    lat   = -1;
    nbusy = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
      if (busy) nbusy++;
      if (j % 3 == 0) A = W'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || Y !== '0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b Y=%h, required 0 0 00", busy, done, Y);
    end
  endtask

  task automatic test_basic();
    int lat, nb, bad;
    run_op(8'hF3, lat, nb);
    vecs++;
    if (lat !== 9) begin
      errs++;
      $display("FAIL basic_latency: done at negedge %0d, required 9", lat);
    end
    vecs++;
    if (nb !== 8) begin
      errs++;
      $display("FAIL basic_busy: busy for %0d cycles, required 8", nb);
    end
    vecs++;
    if (Y !== 8'h0D) begin
      errs++;
      $display("FAIL basic_result: Y=%h, required 0d", Y);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      A = W'($urandom);
      if (Y !== 8'h0D || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL basic_hold: %0d idle cycles off, last Y=%h done=%b, required Y=0d done=0", bad,
               Y, done);
    end
  endtask

  task automatic test_values();
    logic [W-1:0] a, exp;
    int lat, nb;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: a = 8'h05;
        1: a = 8'h00;
        2: a = 8'h7F;
        3: a = 8'hFF;
        4: a = 8'h01;
        default: a = W'($urandom);
      endcase
      exp = ref_abs(a);
      run_op(a, lat, nb);
      vecs++;
      if (Y !== exp || lat !== 9 || nb !== 8) begin
        errs++;
        $display("FAIL value A=%h: Y=%h lat=%0d busy=%0d, required Y=%h lat=9 busy=8", a, Y, lat,
                 nb, exp);
      end
      @(negedge clk);
      vecs++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL done_pulse A=%h: done=%b one cycle after, required 0", a, done);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp80;
    int lat, nb;
`ifdef ABS_BITSERIAL_SAT_EN
    exp80 = 8'h7F;
`else
    exp80 = 8'h80;
`endif
    run_op(8'h80, lat, nb);
    vecs++;
    if (Y !== exp80 || lat !== 9) begin
      errs++;
      $display("FAIL most_negative: Y=%h lat=%0d, required Y=%h lat=9", Y, lat, exp80);
    end
    run_op(8'h81, lat, nb);
    vecs++;
    if (Y !== 8'h7F || lat !== 9) begin
      errs++;
      $display("FAIL near_negative: Y=%h lat=%0d, required Y=7f lat=9", Y, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int ndone, first, busy_after;
    logic [W-1:0] y_at_done;
    start = 1'b1;
    A     = 8'hFF;
    @(posedge clk);
    #1;
    start      = 1'b0;
    ndone      = 0;
    first      = -1;
    busy_after = 0;
    y_at_done  = '0;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first     = j;
          y_at_done = Y;
        end
      end else if (first > 0 && busy) begin
        busy_after++;
      end
      if (j == 3) begin
        start = 1'b1;
        A     = 8'h10;
      end
      if (j == 6) start = 1'b0;
    end
    vecs++;
    if (ndone !== 1 || first !== 9) begin
      errs++;
      $display("FAIL start_in_run: %0d done pulses first at %0d, required 1 at 9", ndone, first);
    end
    vecs++;
    if (y_at_done !== 8'h01 || busy_after !== 0) begin
      errs++;
      $display("FAIL start_in_run_result: Y=%h busy_after=%0d, required Y=01 busy_after=0",
               y_at_done, busy_after);
    end
  endtask

  task automatic test_mid_reset();
    int ndone, lat, nb;
    logic [W-1:0] a;
    start = 1'b1;
    A     = 8'h9C;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || Y !== '0) begin
      errs++;
      $display("FAIL mid_reset_state: busy=%b done=%b Y=%h, required 0 0 00", busy, done, Y);
    end
    ndone = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    vecs++;
    if (ndone !== 0) begin
      errs++;
      $display("FAIL mid_reset_quiet: %0d busy/done cycles after reset, required 0", ndone);
    end
    a = W'($urandom) | 8'h80;
    run_op(a, lat, nb);
    vecs++;
    if (Y !== ref_abs(a) || lat !== 9) begin
      errs++;
      $display("FAIL after_reset A=%h: Y=%h lat=%0d, required Y=%h lat=9", a, Y, lat, ref_abs(a));
    end
    @(negedge clk);
  endtask

  // start held high; the next operand is presented in each DONE cycle.
  task automatic test_back_to_back(input logic [W-1:0] ops[4], input int n);
    int k, prev, idle_seen;
    start     = 1'b1;
    A         = ops[0];
    k         = 0;
    prev      = 0;
    idle_seen = 0;
    @(posedge clk);
    #1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (done) begin
        vecs++;
        if (Y !== ref_abs(ops[k]) || j - prev !== 9) begin
          errs++;
          $display("FAIL back_to_back op%0d A=%h: Y=%h period=%0d, required Y=%h period=9", k,
                   ops[k], Y, j - prev, ref_abs(ops[k]));
        end
        prev = j;
        k++;
        if (k == n) begin
          start = 1'b0;
          break;
        end
        A = ops[k];
      end else begin
        if (!busy) idle_seen++;
        A = W'($urandom);
      end
    end
    vecs++;
    if (k !== n || idle_seen !== 0) begin
      errs++;
      $display("FAIL back_to_back_flow: %0d results, %0d idle cycles, required %0d and 0", k,
               idle_seen, n);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ops[4];
    rst_n = 1'b1;
    start = 1'b0;
    A     = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_values();
    test_wrap();
    test_start_ignored();
    test_mid_reset();
    ops[0] = 8'hFE;
    ops[1] = 8'h02;
    ops[2] = '0;
    ops[3] = '0;
    test_back_to_back(ops, 2);
    for (int i = 0; i < 4; i++) ops[i] = W'($urandom);
    test_back_to_back(ops, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
